fifo_producer: RTL and testbench
================================

Name: fifo_producer

Overview:
- Write-side traffic source for the asynchronous FIFO. Runs in the clk1 (write) clock domain.
- Produces a deterministic, self-checking data stream in bursts separated by idle gaps, driving Data_in/Write into the FIFO write port.
- Obeys Full (already synchronized to clk1 by the FIFO control unit).
- Is the upstream counterpart to the clk2-side consumer.

Parameters:
- WIDTH, 1024, data word width; must be a multiple of 32.
- TOTAL_WORDS, 512, words per run (default equals FIFO DEPTH); must be ≥1.
- BURST_LEN, 16, words per burst; must be ≥1.
- GAP_CYCLES, 4, idle clk1 cycles between bursts; 0 = continuous stream.

Ports:
- clk1  input  1  write-domain clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  begin a run; sampled only in IDLE or DONE
- Full  input  1  FIFO full flag from control unit (clk1 domain)
- Write  output  1  write enable to FIFO
- Data_in  output  WIDTH  data word to FIFO
- Busy  output  1  high in BURST or GAP
- Done  output  1  high in DONE until next Start
- Words_sent  output  $clog2(TOTAL_WORDS+1)  count of accepted words in current run

Behaviour:
- Reset (async assert, sync deassert to clk1): state IDLE; Write=0; Data_in=0; Busy=0; Done=0; Words_sent=0; all internal counters 0.
- All outputs are registered. No combinational path from Full to Write.
- Transfer rule: a word is accepted on a clk1 edge where Write=1 and Full=0.
  - Write=1 with Full=1 means no transfer: Write, Data_in and all counters hold unchanged, indefinitely.
- Data pattern for word index i (0-based within the run): 32-bit lane k (bits 32k+31:32k) = {k[7:0], i[23:0]}.
- State IDLE:
  - Start=1 at edge N → BURST.
  - After edge N: Write=1, Data_in=pattern(0), Busy=1, Words_sent=0, burst count=0.
- State BURST, on an accepted word:
  - Words_sent += 1; burst count += 1.
  - If Words_sent reaches TOTAL_WORDS → DONE; Write=0; Busy=0; Done=1; Data_in holds last word.
  - Else if burst count reaches BURST_LEN and GAP_CYCLES>0 → GAP; Write=0; burst count=0; gap count=0.
  - Else if burst count reaches BURST_LEN and GAP_CYCLES=0 → burst count=0; stay in BURST with Write=1 and the next word (no bubble).
  - Else Write stays 1 and Data_in = pattern(Words_sent), giving back-to-back writes at one word per cycle.
  - Completing TOTAL_WORDS takes priority over ending a burst.
- State GAP:
  - Gap count increments every cycle, independent of Full.
  - After exactly GAP_CYCLES cycles with Write=0 → BURST; Write=1 with the next word.
- State DONE:
  - Done=1, Write=0.
  - Start=1 → BURST with index restarted at 0: Words_sent=0, Done=0, Busy=1, Write=1, Data_in=pattern(0).
- Start is ignored in BURST and GAP.
- Reset mid-run: immediate return to the reset values above. Any unaccepted word is dropped; the FIFO resets alongside.
- Counter widths: burst count $clog2(BURST_LEN+1); gap count $clog2(GAP_CYCLES+1), minimum 1 bit. No counter wraps within a run.

Decomposition:
- Shared package fifo_pkg holds:
  - WIDTH, DEPTH, PTR_WIDTH;
  - typedef enum producer_state_t {IDLE, BURST, GAP, DONE};
  - function pattern_word(index) returning a WIDTH-bit word, reused by the consumer-side checker.
- No sub-module: a single FSM with three counters is natural.

Test Plan (WIDTH=64, TOTAL_WORDS=10, BURST_LEN=4, GAP_CYCLES=2 unless stated):
- Reset then Start pulse, Full=0 → Write high for 4 cycles carrying index 0..3, low for 2 cycles, then 4..7, low for 2 cycles, then 8..9. Done=1 after the 10th accept; Words_sent=10. Lane 1 of word 5 = 0x01000005.
- Full=1 for 5 cycles while presenting index 2 → Write=1 and Data_in=index 2 held for all 5 cycles; Words_sent stays 2; index 2 is accepted on the first edge with Full=0; no word duplicated or skipped.
- GAP_CYCLES=0, BURST_LEN=4 → 10 consecutive write cycles with indices 0..9 and no bubble.
- Start pulsed during BURST and GAP → ignored. Start in DONE → new run from index 0, Done drops on the next cycle.
- rst_n asserted asynchronously mid-BURST (between edges) → Write, Busy and Done go to 0 immediately with no clock edge. After release, no write occurs until Start.
- TOTAL_WORDS=8, BURST_LEN=4 → the last accepted word goes to DONE, not GAP; Write=0 on the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: geometry, producer state encoding and the test data pattern
// used by both the write-side producer and the read-side checker.
package fifo_pkg;

  localparam int WIDTH     = 1024;
  localparam int DEPTH     = 512;
  localparam int PTR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } producer_state_t;

  // One 32-bit lane of word `index`: the lane number on top, the word index below.
  function automatic logic [31:0] pattern_lane(input logic [7:0] lane, input logic [23:0] index);
    return {lane, index};
  endfunction

  function automatic logic [WIDTH-1:0] pattern_word(input logic [23:0] index);
    logic [WIDTH-1:0] word;
    word = '0;
    for (int k = 0; k < WIDTH / 32; k++) begin
      word[32*k +: 32] = pattern_lane(8'(k), index);
    end
    return word;
  endfunction

endpackage

// File: rtl/fifo_producer.sv
// Write-side traffic source: emits TOTAL_WORDS pattern words in bursts of BURST_LEN,
// separated by GAP_CYCLES idle cycles, stalling on Full without losing or repeating words.
module fifo_producer #(
  parameter int WIDTH       = 1024,
  parameter int TOTAL_WORDS = 512,
  parameter int BURST_LEN   = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                                 clk1,
  input  logic                                 rst_n,
  input  logic                                 Start,
  input  logic                                 Full,
  output logic                                 Write,
  output logic [WIDTH-1:0]                     Data_in,
  output logic                                 Busy,
  output logic                                 Done,
  output logic [$clog2(TOTAL_WORDS+1)-1:0]     Words_sent
);
  import fifo_pkg::*;

  localparam int WW = $clog2(TOTAL_WORDS + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [WW-1:0] WORDS_LAST = WW'(TOTAL_WORDS - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  producer_state_t   r_state;
  logic              r_write;
  logic [WIDTH-1:0]  r_data;
  logic              r_busy;
  logic              r_done;
  logic [WW-1:0]     r_words;
  logic [BW-1:0]     r_burst;
  logic [GW-1:0]     r_gap;

  logic              w_accept;
  logic [23:0]       w_idx;
  logic [WIDTH-1:0]  w_pattern;

  assign w_accept = r_write & ~Full;

  // Index of the word to load next: in BURST the one after the word being accepted,
  // on leaving GAP the first unsent word, and 0 when a run starts.
  always_comb begin
    w_idx = '0;
    case (r_state)
      BURST:   w_idx = 24'(r_words) + 24'd1;
      GAP:     w_idx = 24'(r_words);
      default: w_idx = '0;
    endcase
  end

  for (genvar gi = 0; gi < WIDTH / 32; gi++) begin : g_lane
    assign w_pattern[32*gi +: 32] = pattern_lane(8'(gi), w_idx);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_words <= '0;
      r_burst <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (Start) begin
            r_state <= BURST;
            r_write <= 1'b1;
            r_data  <= w_pattern;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_words <= '0;
            r_burst <= '0;
            r_gap   <= '0;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_words <= r_words + 1'b1;
            if (r_words == WORDS_LAST) begin
              r_state <= DONE;
              r_write <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_burst <= '0;
            end else if (r_burst == BURST_LAST) begin
              r_burst <= '0;
              if (GAP_CYCLES > 0) begin
                r_state <= GAP;
                r_write <= 1'b0;
                r_gap   <= '0;
              end else begin
                r_data <= w_pattern;
              end
            end else begin
              r_burst <= r_burst + 1'b1;
              r_data  <= w_pattern;
            end
          end
        end
        GAP: begin
          // Data_in keeps the last word while idle; the next word is loaded on exit.
          if (r_gap == GAP_LAST) begin
            r_state <= BURST;
            r_write <= 1'b1;
            r_data  <= w_pattern;
            r_gap   <= '0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Write      = r_write;
  assign Data_in    = r_data;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Words_sent = r_words;

endmodule

// File: tb/tb_fifo_producer.sv
// Three producers (gapped, gapless, short run) driven with directed and random Start/Full,
// each checked every cycle against a word-count based reference model.
module tb_fifo_producer;

  localparam int N = 3;
  localparam int TW[N] = '{10, 10, 8};
  localparam int GC[N] = '{2, 0, 2};
  localparam int BL    = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   start_i;
  logic [N-1:0]   full_i;
  logic [N-1:0]   write_o;
  logic [N-1:0]   busy_o;
  logic [N-1:0]   done_o;
  logic [63:0]    data_o [N];
  logic [3:0]     ws_o   [N];

  int n_checks;
  int n_fail;

  // reference model state, per instance
  int          m_sent [N];
  int          m_gap  [N];
  bit          m_busy [N];
  bit          m_done [N];
  bit          m_write[N];
  logic [63:0] m_data [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    fifo_producer #(
      .WIDTH(64), .TOTAL_WORDS(TW[gi]), .BURST_LEN(BL), .GAP_CYCLES(GC[gi])
    ) u_dut (
      .clk1(clk), .rst_n(rst_n), .Start(start_i[gi]), .Full(full_i[gi]),
      .Write(write_o[gi]), .Data_in(data_o[gi]), .Busy(busy_o[gi]),
      .Done(done_o[gi]), .Words_sent(ws_o[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat(input int idx);
    logic [23:0] i24;
    i24 = 24'(idx);
    return {8'd1, i24, 8'd0, i24};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_sent[i] = 0; m_gap[i] = 0; m_busy[i] = 0;
      m_done[i] = 0; m_write[i] = 0; m_data[i] = '0;
    end
  endfunction

  // One clock edge of instance i, expressed in terms of words sent so far.
  function automatic void model_step(input int i, input bit st, input bit fl);
    if (!m_busy[i]) begin
      if (st) begin
        m_busy[i] = 1; m_done[i] = 0; m_sent[i] = 0; m_gap[i] = 0;
        m_write[i] = 1; m_data[i] = pat(0);
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
      if (m_gap[i] == 0) begin
        m_write[i] = 1; m_data[i] = pat(m_sent[i]);
      end
    end else if (!fl) begin
      m_sent[i]++;
      if (m_sent[i] == TW[i]) begin
        m_busy[i] = 0; m_done[i] = 1; m_write[i] = 0;
      end else if ((m_sent[i] % BL) == 0 && GC[i] > 0) begin
        m_write[i] = 0; m_gap[i] = GC[i];
      end else begin
        m_data[i] = pat(m_sent[i]);
      end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("write[%0d]", i), 64'(write_o[i]), 64'(m_write[i]));
      check_eq($sformatf("busy[%0d]", i), 64'(busy_o[i]), 64'(m_busy[i]));
      check_eq($sformatf("done[%0d]", i), 64'(done_o[i]), 64'(m_done[i]));
      check_eq($sformatf("words_sent[%0d]", i), 64'(ws_o[i]), 64'(m_sent[i]));
      if (m_write[i] || m_done[i] || !m_busy[i])
        check_eq($sformatf("data[%0d]", i), data_o[i], m_data[i]);
    end
  endtask

  task automatic cycle(input logic [N-1:0] st, input logic [N-1:0] fl);
    start_i = st;
    full_i  = fl;
    @(posedge clk);
    for (int i = 0; i < N; i++) model_step(i, st[i], fl[i]);
    #1;
    check_all();
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("arst_write[%0d]", i), 64'(write_o[i]), 64'd0);
      check_eq($sformatf("arst_busy[%0d]", i), 64'(busy_o[i]), 64'd0);
      check_eq($sformatf("arst_done[%0d]", i), 64'(done_o[i]), 64'd0);
    end
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_i  = '0;
    full_i   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // full-speed run from reset
    cycle('1, '0);
    for (int c = 0; c < 20; c++) begin
      cycle('0, '0);
      if (c == 0) $display("run1: first burst in progress, words_sent=%0d", ws_o[0]);
      if (m_write[0] && m_sent[0] == 5)
        check_eq("lane1_word5", 64'(data_o[0][63:32]), 64'h0100_0005);
    end
    $display("run1 complete: done=%b words_sent=%0d", done_o[0], ws_o[0]);

    // restart from DONE, then stall on word 2 for five cycles
    cycle('1, '0);
    guard = 0;
    while (m_sent[0] != 2 && guard < 20) begin
      cycle('0, '0);
      guard++;
    end
    check_eq("reach_word2", 64'(m_sent[0]), 64'd2);
    for (int c = 0; c < 5; c++) cycle('0, '1);
    $display("stall released: words_sent=%0d data=0x%0h", ws_o[0], data_o[0]);
    for (int c = 0; c < 20; c++) cycle('0, '0);

    // random Start (including mid-run) and random Full
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] st, fl;
      for (int i = 0; i < N; i++) begin
        st[i] = ($urandom_range(0, 7) == 0);
        fl[i] = ($urandom_range(0, 2) == 0);
      end
      cycle(st, fl);
    end
    $display("random phase complete: %0d checks so far", n_checks);

    // asynchronous reset mid-burst, then no writes until Start
    async_reset();
    cycle('1, '0);
    cycle('0, '0);
    async_reset();
    for (int c = 0; c < 5; c++) cycle('0, '0);
    cycle('1, '0);
    for (int c = 0; c < 20; c++) cycle('0, '0);
    $display("post-reset run: done=%b%b%b", done_o[2], done_o[1], done_o[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
